// File: rtl/multich_noise_adder.sv
// Multichannel AWGN adder: data + noise*sigma, round-half-up, saturate; sigma swaps on symbol boundaries.
// Define MULTICH_NOISE_SAT_CNT_EN to build the saturation counter; otherwise o_sat_count is tied to 0.
module multich_noise_adder #(
  parameter int NCH = 2,
  parameter int NBT_IN = 8,
  parameter int NBF_IN = 6,
  parameter int NBT_NOISE = 8,
  parameter int NBF_NOISE = 7,
  parameter int NBT_SIGMA = 8,
  parameter int NBF_SIGMA = 7,
  parameter int NBT_OUT = 8,
  parameter int NBF_OUT = 6,
  parameter int OVERSAMP = 4,
  parameter logic [NBT_SIGMA-1:0] SIGMA_RST = 8'h1c,
  parameter int NBT_CNT = 16
) (
  input  logic                                              clk,
  input  logic                                              i_reset,
  input  logic                                              i_valid,
  input  logic [NCH*NBT_IN-1:0]                             i_data,
  input  logic [NCH*NBT_NOISE-1:0]                          i_noise,
  input  logic                                              i_noise_en,
  input  logic [NBT_SIGMA-1:0]                              i_sigma,
  input  logic                                              i_sigma_load,
  output logic                                              o_valid,
  output logic [NCH*NBT_OUT-1:0]                            o_data,
  output logic [NCH-1:0]                                    o_sat,
  output logic [((OVERSAMP > 1) ? $clog2(OVERSAMP) : 1)-1:0] o_phase,
  output logic [NBT_CNT-1:0]                                o_sat_count
);

  localparam int PH_W   = (OVERSAMP > 1) ? $clog2(OVERSAMP) : 1;
  localparam int PROD_W = NBT_NOISE + NBT_SIGMA + 1;
  localparam int PF     = NBF_NOISE + NBF_SIGMA;
  localparam int FA     = (NBF_IN > PF) ? NBF_IN : PF;
  localparam int IA     = ((NBT_IN - NBF_IN) > (PROD_W - PF)) ? (NBT_IN - NBF_IN) : (PROD_W - PF);
  localparam int SUM_W  = IA + FA + 1;
  localparam int DSH    = FA - NBF_IN;
  localparam int PSH    = FA - PF;
  localparam int SH     = FA - NBF_OUT;
  localparam int RND_W  = SUM_W + 1 - SH;
  localparam logic signed [SUM_W:0]   RND_C   = (SUM_W + 1)'(1) << (SH - 1);
  localparam logic signed [RND_W-1:0] OUT_MAX = {{(RND_W-NBT_OUT+1){1'b0}}, {(NBT_OUT-1){1'b1}}};
  localparam logic signed [RND_W-1:0] OUT_MIN = {{(RND_W-NBT_OUT+1){1'b1}}, {(NBT_OUT-1){1'b0}}};

  // The extra top bit of t keeps the +half from overflowing before the shift.
  function automatic logic signed [RND_W-1:0] round_hu(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W:0] t;
    t = {s[SUM_W-1], s} + RND_C;
    return t[SUM_W:SH];
  endfunction

  function automatic logic is_clip(input logic signed [RND_W-1:0] r);
    return (r > OUT_MAX) || (r < OUT_MIN);
  endfunction

  function automatic logic [NBT_OUT-1:0] sat_out(input logic signed [RND_W-1:0] r);
    if (r > OUT_MAX) return OUT_MAX[NBT_OUT-1:0];
    if (r < OUT_MIN) return OUT_MIN[NBT_OUT-1:0];
    return r[NBT_OUT-1:0];
  endfunction

  logic [PH_W-1:0]        phase_q, phase_d;
  logic [NBT_SIGMA-1:0]   sigma_act_q, sigma_act_d;
  logic [NBT_SIGMA-1:0]   sigma_pend_q, sigma_pend_d;
  logic                   pend_flag_q, pend_flag_d;
  logic [NBT_SIGMA-1:0]   sigma_use;

  logic                   vld_p1_q, vld_p1_d;
  logic [PH_W-1:0]        ph_p1_q, ph_p1_d;
  logic signed [NBT_IN-1:0] data_p1_q [NCH];
  logic signed [NBT_IN-1:0] data_p1_d [NCH];
  logic signed [PROD_W-1:0] prod_p1_q [NCH];
  logic signed [PROD_W-1:0] prod_p1_d [NCH];

  logic                   vld_p2_q, vld_p2_d;
  logic [PH_W-1:0]        ph_p2_q, ph_p2_d;
  logic signed [SUM_W-1:0] sum_p2_q [NCH];
  logic signed [SUM_W-1:0] sum_p2_d [NCH];

  logic                   vld_p3_q, vld_p3_d;
  logic [PH_W-1:0]        ph_p3_q, ph_p3_d;
  logic [NCH*NBT_OUT-1:0] data_p3_q, data_p3_d;
  logic [NCH-1:0]         sat_p3_q, sat_p3_d;

  // Stage 1: phase tracking, sigma boundary swap, noise scaling
  always_comb begin
    phase_d      = phase_q;
    sigma_act_d  = sigma_act_q;
    sigma_pend_d = sigma_pend_q;
    pend_flag_d  = pend_flag_q;
    sigma_use    = sigma_act_q;
    if (i_valid) begin
      phase_d = (phase_q == PH_W'(OVERSAMP - 1)) ? '0 : phase_q + PH_W'(1);
      if ((phase_q == '0) && pend_flag_q) begin
        sigma_use   = sigma_pend_q;
        sigma_act_d = sigma_pend_q;
        pend_flag_d = 1'b0;
      end
    end
    // A load coinciding with the swap must survive it and wait for the next symbol.
    if (i_sigma_load) begin
      sigma_pend_d = i_sigma;
      pend_flag_d  = 1'b1;
    end
    vld_p1_d = i_valid;
    ph_p1_d  = phase_q;
    for (int k = 0; k < NCH; k++) begin
      data_p1_d[k] = i_data[k*NBT_IN +: NBT_IN];
      prod_p1_d[k] = i_noise_en
        ? PROD_W'(signed'(i_noise[k*NBT_NOISE +: NBT_NOISE])) * PROD_W'(signed'({1'b0, sigma_use}))
        : '0;
    end
  end

  // Stage 2: align to FA fractional bits and add with one guard bit
  always_comb begin
    vld_p2_d = vld_p1_q;
    ph_p2_d  = ph_p1_q;
    for (int k = 0; k < NCH; k++) begin
      sum_p2_d[k] = (SUM_W'(data_p1_q[k]) <<< DSH) + (SUM_W'(prod_p1_q[k]) <<< PSH);
    end
  end

  // Stage 3: round half-up, saturate, flag clipping
  always_comb begin
    vld_p3_d  = vld_p2_q;
    ph_p3_d   = ph_p3_q;
    data_p3_d = data_p3_q;
    sat_p3_d  = '0;
    if (vld_p2_q) begin
      ph_p3_d = ph_p2_q;
      for (int k = 0; k < NCH; k++) begin
        data_p3_d[k*NBT_OUT +: NBT_OUT] = sat_out(round_hu(sum_p2_q[k]));
        sat_p3_d[k]                     = is_clip(round_hu(sum_p2_q[k]));
      end
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      phase_q      <= '0;
      sigma_act_q  <= SIGMA_RST;
      sigma_pend_q <= SIGMA_RST;
      pend_flag_q  <= 1'b0;
      vld_p1_q     <= 1'b0;
      ph_p1_q      <= '0;
      vld_p2_q     <= 1'b0;
      ph_p2_q      <= '0;
      vld_p3_q     <= 1'b0;
      ph_p3_q      <= '0;
      data_p3_q    <= '0;
      sat_p3_q     <= '0;
    end else begin
      phase_q      <= phase_d;
      sigma_act_q  <= sigma_act_d;
      sigma_pend_q <= sigma_pend_d;
      pend_flag_q  <= pend_flag_d;
      vld_p1_q     <= vld_p1_d;
      ph_p1_q      <= ph_p1_d;
      vld_p2_q     <= vld_p2_d;
      ph_p2_q      <= ph_p2_d;
      vld_p3_q     <= vld_p3_d;
      ph_p3_q      <= ph_p3_d;
      data_p3_q    <= data_p3_d;
      sat_p3_q     <= sat_p3_d;
    end
  end

  // Inner data registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    data_p1_q <= data_p1_d;
    prod_p1_q <= prod_p1_d;
    sum_p2_q  <= sum_p2_d;
  end

`ifdef MULTICH_NOISE_SAT_CNT_EN
  logic [NBT_CNT-1:0] sat_cnt_q, sat_cnt_d;
  logic [NBT_CNT:0]   cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, sat_cnt_q};
    for (int k = 0; k < NCH; k++) begin
      cnt_sum = cnt_sum + (NBT_CNT + 1)'(sat_p3_d[k]);
    end
    sat_cnt_d = cnt_sum[NBT_CNT] ? '1 : cnt_sum[NBT_CNT-1:0];
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) sat_cnt_q <= '0;
    else         sat_cnt_q <= sat_cnt_d;
  end

  assign o_sat_count = sat_cnt_q;
`else
  assign o_sat_count = '0;
`endif

  assign o_valid = vld_p3_q;
  assign o_data  = data_p3_q;
  assign o_sat   = sat_p3_q;
  assign o_phase = ph_p3_q;

endmodule
